ldpc_wb_cword_ctrl: RTL and testbench

// Wishbone-slave front end for the LDPC decoder core. Management SoC writes an NN-bit noisy codeword
// as 32-bit words and starts a decode. The block drives the decoder's codeword/start/loop-max inputs,

---
 rtl/ldpc_wb_cword_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ldpc_wb_cword_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_wb_cword_ctrl.sv
// rtl/ldpc_wb_cword_ctrl.sv - Wishbone front end that loads, launches and collects LDPC decoder codewords
module ldpc_wb_cword_ctrl #(
  parameter int          NN        = 128,
  parameter int          SUM_LEN   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TMO_W     = 20
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [NN-1:0]      dec_y_nr_o,
  output logic [SUM_LEN-1:0] dec_loop_max_o,
  output logic               dec_start_o,
  input  logic               dec_converged_i,
  input  logic               dec_pass_fail_i,
  input  logic [NN-1:0]      dec_final_y_i,
  output logic               irq_o
);

  localparam int NW = NN / 32;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic               ack_q;
  logic [31:0]        dat_q;
  logic [NN-1:0]      cword_in_q, cword_out_q;
  logic [SUM_LEN-1:0] loop_max_q;
  logic               irq_en_q, done_q, pass_q, tmo_q, irq_q, start_q;
  logic [TMO_W-1:0]   timer_q, timer_inc;

  logic               start_d, conv_hit, tmo_hit, abort_hit;
  logic               irq_en_d, done_d, pass_d, tmo_d;

  // Bus decode: only word-aligned offsets inside the 256-byte window are mapped
  logic        addr_hit, req, wr, aligned, idle_wr;
  logic [5:0]  woff;
  logic [3:0]  widx;
  logic        is_ctrl, is_status, is_loop, is_cw_in, is_cw_out;
  logic        ctrl_wr, start_cmd, abort_cmd, clr_cmd, loop_wr, cw_in_wr;
  logic [31:0] rdata, cw_in_word, cw_out_word, lm_ext, lm_merged, cw_in_merged;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  assign addr_hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req       = wbs_cyc_i & wbs_stb_i & addr_hit & ~ack_q;
  assign wr        = req & wbs_we_i;
  assign aligned   = (wbs_adr_i[1:0] == 2'b00);
  assign woff      = wbs_adr_i[7:2];
  assign widx      = woff[3:0];
  assign is_ctrl   = aligned && (woff == 6'h00);
  assign is_status = aligned && (woff == 6'h01);
  assign is_loop   = aligned && (woff == 6'h02);
  assign is_cw_in  = aligned && (woff[5:4] == 2'b01) && (int'(widx) < NW);
  assign is_cw_out = aligned && (woff[5:4] == 2'b10) && (int'(widx) < NW);

  assign idle_wr   = wr && (state_q == ST_IDLE);
  assign ctrl_wr   = wr && is_ctrl && wbs_sel_i[0];
  assign start_cmd = ctrl_wr && wbs_dat_i[0];
  assign abort_cmd = ctrl_wr && wbs_dat_i[2];
  assign clr_cmd   = wr && is_status && wbs_sel_i[0] && wbs_dat_i[1];
  assign loop_wr   = idle_wr && is_loop;
  assign cw_in_wr  = idle_wr && is_cw_in;

  assign lm_ext       = 32'(loop_max_q);
  assign lm_merged    = merge_bytes(lm_ext, wbs_dat_i, wbs_sel_i);
  assign cw_in_merged = merge_bytes(cw_in_word, wbs_dat_i, wbs_sel_i);

  // Select the addressed codeword slice from the input and output buffers
  always_comb begin
    cw_in_word  = '0;
    cw_out_word = '0;
    for (int w = 0; w < NW; w++) begin
      if (widx == 4'(w)) begin
        cw_in_word  = cword_in_q[32*w +: 32];
        cw_out_word = cword_out_q[32*w +: 32];
      end
    end
  end

  // Read-data mux; unmapped offsets return zero
  always_comb begin
    rdata = '0;
    if (is_ctrl)        rdata = {30'd0, irq_en_q, 1'b0};
    else if (is_status) rdata = {28'd0, tmo_q, pass_q, done_q, (state_q == ST_RUN)};
    else if (is_loop)   rdata = lm_ext;
    else if (is_cw_in)  rdata = cw_in_word;
    else if (is_cw_out) rdata = cw_out_word;
  end

  // Decode FSM: launch on START, finish on converge, timeout or abort (converge has priority)
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    conv_hit  = 1'b0;
    tmo_hit   = 1'b0;
    abort_hit = 1'b0;
    timer_inc = (timer_q == TMO_MAX) ? timer_q : timer_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start_cmd) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (dec_converged_i) begin
          conv_hit = 1'b1;
          state_d  = ST_IDLE;
        end else if (timer_inc == TMO_MAX) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end else if (abort_cmd) begin
          abort_hit = 1'b1;
          state_d   = ST_IDLE;
        end
      end
    endcase
  end

  // Status flag updates; a completion in the same cycle as a clear wins
  always_comb begin
    irq_en_d = irq_en_q;
    done_d   = done_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    if (ctrl_wr) irq_en_d = wbs_dat_i[1];
    if (clr_cmd || start_d) begin
      done_d = 1'b0;
      pass_d = 1'b0;
      tmo_d  = 1'b0;
    end
    if (conv_hit) begin
      done_d = 1'b1;
      pass_d = dec_pass_fail_i;
      tmo_d  = 1'b0;
    end else if (tmo_hit) begin
      done_d = 1'b1;
      pass_d = 1'b0;
      tmo_d  = 1'b1;
    end else if (abort_hit) begin
      done_d = 1'b0;
    end
  end

  // FSM state, start pulse and saturating run timer
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      if (start_d)                  timer_q <= '0;
      else if (state_q == ST_RUN)   timer_q <= timer_inc;
    end
  end

  // Register file: flags, irq, loop max, codeword buffers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tmo_q       <= 1'b0;
      irq_q       <= 1'b0;
      loop_max_q  <= '0;
      cword_in_q  <= '0;
      cword_out_q <= '0;
    end else begin
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      irq_q    <= done_d & irq_en_d;
      if (conv_hit) cword_out_q <= dec_final_y_i;
      if (loop_wr)  loop_max_q  <= lm_merged[SUM_LEN-1:0];
      for (int w = 0; w < NW; w++) begin
        if (cw_in_wr && (widx == 4'(w))) cword_in_q[32*w +: 32] <= cw_in_merged;
      end
    end
  end

  // Registered single-cycle acknowledge with read data valid only alongside it
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs_we_i) ? rdata : '0;
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign dec_y_nr_o     = cword_in_q;
  assign dec_loop_max_o = loop_max_q;
  assign dec_start_o    = start_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_ldpc_wb_cword_ctrl.sv
// tb/tb_ldpc_wb_cword_ctrl.sv - self-checking bench for ldpc_wb_cword_ctrl
module tb_ldpc_wb_cword_ctrl;
  localparam int          NN      = 128;
  localparam int          SUM_LEN = 16;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam int          TMO_W   = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               cyc, stb, we;
  logic [3:0]         sel;
  logic [31:0]        adr, wdat;
  logic               ack;
  logic [31:0]        rdat;
  logic [NN-1:0]      dec_y;
  logic [SUM_LEN-1:0] dec_loop;
  logic               dec_start;
  logic               dec_conv = 1'b0;
  logic               dec_pf = 1'b0;
  logic [NN-1:0]      dec_fy = '0;
  logic               irq;

  always #5 clk = ~clk;

  ldpc_wb_cword_ctrl #(.NN(NN), .SUM_LEN(SUM_LEN), .BASE_ADDR(BASE), .TMO_W(TMO_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .dec_y_nr_o(dec_y), .dec_loop_max_o(dec_loop), .dec_start_o(dec_start),
    .dec_converged_i(dec_conv), .dec_pass_fail_i(dec_pf), .dec_final_y_i(dec_fy),
    .irq_o(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Read scoreboard: expectations queued when a read is issued, compared on ack
  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;
  rd_exp_t rd_q[$];
  rd_exp_t mon_e;

  always @(negedge clk) begin
    if (ack === 1'b1 && we === 1'b0) begin
      if (rd_q.size() == 0) check("unexpected_read_ack", 1'b1, 1'b0);
      else begin
        mon_e = rd_q.pop_front();
        check(mon_e.name, rdat, mon_e.exp);
      end
    end
  end

  // Decoder stub: raises converged stub_delay cycles after the start pulse and holds it
  int          stub_delay   = -1;
  logic        stub_pass    = 1'b0;
  logic [NN-1:0] stub_y     = '0;
  int          since_start  = 0;
  int          start_pulses = 0;

  always @(posedge clk) begin
    #2;
    since_start++;
    if (dec_start === 1'b1) begin
      since_start  = 0;
      start_pulses++;
      dec_conv     = 1'b0;
    end else if (since_start == stub_delay) begin
      dec_conv = 1'b1;
      dec_pf   = stub_pass;
      dec_fy   = stub_y;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic exp_ack, input string name);
    logic got;
    got  = 1'b0;
    cyc  = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack === 1'b1) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    check({name, "_ack"}, got, exp_ack);
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s, input string name);
    wb_xfer(1'b1, BASE + 32'(off), d, s, 1'b1, name);
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] exp, input string name);
    rd_q.push_back('{name, exp});
    wb_xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF, 1'b1, name);
  endtask

  task automatic wait_irq(input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound && lat < 0; i++) begin
      @(negedge clk);
      if (irq === 1'b1) lat = since_start;
    end
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [19];

  logic [NN-1:0] cw_init;
  logic [NN-1:0] y_mix;
  logic [31:0]   tword;
  logic [7:0]    ack_pat;
  int            lat;
  int            sp0;

  initial begin
    cw_init = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    y_mix   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    vecs[0]  = '{1'b1, 8'h40, 32'hA5A5_0000, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 8'h44, 32'hA5A5_0001, 4'hF, 32'h0};
    vecs[2]  = '{1'b1, 8'h48, 32'hA5A5_0002, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 8'h4C, 32'hA5A5_0003, 4'hF, 32'h0};
    vecs[4]  = '{1'b1, 8'h08, 32'h0000_1234, 4'hF, 32'h0};
    vecs[5]  = '{1'b0, 8'h40, 32'h0,         4'hF, 32'hA5A5_0000};
    vecs[6]  = '{1'b0, 8'h4C, 32'h0,         4'hF, 32'hA5A5_0003};
    vecs[7]  = '{1'b0, 8'h08, 32'h0,         4'hF, 32'h0000_1234};
    vecs[8]  = '{1'b1, 8'h08, 32'hABCD_5678, 4'b0010, 32'h0};
    vecs[9]  = '{1'b0, 8'h08, 32'h0,         4'hF, 32'h0000_5634};
    vecs[10] = '{1'b1, 8'h08, 32'hFFFF_0020, 4'b0011, 32'h0};
    vecs[11] = '{1'b0, 8'h08, 32'h0,         4'hF, 32'h0000_0020};
    vecs[12] = '{1'b0, 8'h0C, 32'h0,         4'hF, 32'h0};
    vecs[13] = '{1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[14] = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h0};
    vecs[15] = '{1'b0, 8'h80, 32'h0,         4'hF, 32'h0};
    vecs[16] = '{1'b0, 8'h04, 32'h0,         4'hF, 32'h0};
    vecs[17] = '{1'b1, 8'h80, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[18] = '{1'b0, 8'h80, 32'h0,         4'hF, 32'h0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_dat", rdat, 32'h0);
    check("rst_dec_y", dec_y, 128'h0);
    check("rst_loop", dec_loop, 16'h0);
    check("rst_start", dec_start, 1'b0);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    wb_read(8'h04, 32'h0, "rst_status");

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].w) wb_write(vecs[i].off, vecs[i].dat, vecs[i].sel, $sformatf("vec%0d_wr", i));
      else           wb_read(vecs[i].off, vecs[i].exp, $sformatf("vec%0d_rd", i));
    end
    check("dec_y_loaded", dec_y, cw_init);
    check("dec_loop_loaded", dec_loop, 16'h0020);

    wb_write(8'h44, 32'h0000_FF00, 4'b0010, "byte_wr");
    check("byte_lane_dec_y", dec_y, cw_init | (128'hFF << 40));
    wb_read(8'h44, 32'hA5A5_FF01, "byte_lane_rd");
    wb_write(8'h44, 32'h0000_0000, 4'b0010, "byte_restore");
    check("byte_restore_dec_y", dec_y, cw_init);

    // Converge after 50 cycles with IRQ enabled, exercising writes during RUN
    stub_delay = 50; stub_pass = 1'b1; stub_y = ~cw_init;
    sp0 = start_pulses;
    wb_write(8'h00, 32'h3, 4'h1, "start1");
    check("start_single_pulse_cnt", 32'(start_pulses), 32'(sp0 + 1));
    check("start_pulse_low", dec_start, 1'b0);
    wb_read(8'h04, 32'h1, "status_busy");
    wb_write(8'h40, 32'hFFFF_FFFF, 4'hF, "cw_wr_run");
    wb_write(8'h08, 32'h0000_0007, 4'hF, "loop_wr_run");
    wb_write(8'h00, 32'h3, 4'h1, "start_in_run");
    wb_read(8'h40, 32'hA5A5_0000, "cw_run_dropped");
    wb_read(8'h08, 32'h0000_0020, "loop_run_dropped");
    check("dec_y_stable_run", dec_y, cw_init);
    check("dec_loop_stable_run", dec_loop, 16'h0020);
    wait_irq(150, lat);
    check("conv50_latency", 32'(lat), 32'd51);
    check("start_in_run_ignored", 32'(start_pulses), 32'(sp0 + 1));
    wb_read(8'h04, 32'h6, "status_pass");
    for (int k = 0; k < 4; k++) begin
      tword = 32'hA5A5_0000 + 32'(k);
      wb_read(8'h80 + 8'(4 * k), ~tword, $sformatf("cword_out%0d", k));
    end
    check("irq_done", irq, 1'b1);
    wb_write(8'h04, 32'h2, 4'h1, "status_clr");
    check("irq_cleared", irq, 1'b0);
    wb_read(8'h04, 32'h0, "status_cleared");

    // Converge with fail and IRQ disabled
    stub_delay = 10; stub_pass = 1'b0; stub_y = y_mix;
    wb_write(8'h00, 32'h1, 4'h1, "start_noirq");
    repeat (20) @(negedge clk);
    wb_read(8'h04, 32'h2, "status_fail");
    check("irq_disabled", irq, 1'b0);
    wb_read(8'h88, 32'h89AB_CDEF, "cword_out2_mix");

    // Never converges: timeout 63 cycles after start, output buffer kept
    stub_delay = -1;
    wb_write(8'h00, 32'h3, 4'h1, "start_tmo");
    wait_irq(150, lat);
    check("tmo_latency", 32'(lat), 32'd63);
    wb_read(8'h04, 32'hA, "status_tmo");
    wb_read(8'h88, 32'h89AB_CDEF, "cword_out_kept");

    // Converged in the timeout cycle wins
    stub_delay = 62; stub_pass = 1'b1; stub_y = cw_init;
    wb_write(8'h00, 32'h3, 4'h1, "start_edge");
    wait_irq(150, lat);
    check("edge_latency", 32'(lat), 32'd63);
    wb_read(8'h04, 32'h6, "status_edge_conv");
    wb_read(8'h80, 32'hA5A5_0000, "cword_out_edge");

    // Converged one cycle too late is ignored
    stub_delay = 63;
    wb_write(8'h00, 32'h3, 4'h1, "start_late");
    wait_irq(150, lat);
    check("late_latency", 32'(lat), 32'd63);
    wb_read(8'h04, 32'hA, "status_late_tmo");

    // Abort during RUN
    stub_delay = -1;
    wb_write(8'h00, 32'h3, 4'h1, "start_abort");
    wb_read(8'h04, 32'h1, "status_abort_busy");
    wb_write(8'h00, 32'h6, 4'h1, "abort");
    wb_read(8'h04, 32'h0, "status_aborted");
    check("irq_abort", irq, 1'b0);

    // Held cyc/stb: ack every other cycle
    for (int i = 0; i < 4; i++) rd_q.push_back('{$sformatf("b2b_rd%0d", i), 32'h0000_0020});
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ack_pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("b2b_ack_pattern", ack_pat, 8'b0101_0101);
    check("b2b_queue_drained", 32'(rd_q.size()), 32'd0);
    wb_xfer(1'b0, BASE + 32'h200, 32'h0, 4'hF, 1'b0, "no_ack_0x200");
    check("idle_dat_zero", rdat, 32'h0);

    // Reset in the middle of a decode; the late converge must be ignored
    stub_delay = 30; stub_pass = 1'b1; stub_y = '1;
    wb_write(8'h00, 32'h3, 4'h1, "start_rst");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rstrun_irq", irq, 1'b0);
    check("rstrun_dec_y", dec_y, 128'h0);
    check("rstrun_loop", dec_loop, 16'h0);
    check("rstrun_start", dec_start, 1'b0);
    wb_read(8'h04, 32'h0, "rstrun_status");
    wb_read(8'h80, 32'h0, "rstrun_cword_out");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
